// File: rtl/laser_pulse_gen.sv
// Programmable laser pulse-train generator with a registered drive output, done/cfg_err strobes and sticky abort.
// Define LASER_GEN_SAFETY_ABORT_EN to let safety_fail force a latched FAULT state.
module laser_pulse_gen #(
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             laser_ready,
    input  logic             safety_fail,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [CNT_W-1:0] pulse_period,
    input  logic [NUM_W-1:0] pulse_num,
    output logic             laser_pulse_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             abort_flag,
    output logic [NUM_W-1:0] pulses_sent
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, FAULT} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] width_l;
    logic [CNT_W-1:0] period_l;
    logic [NUM_W-1:0] num_l;
    logic             stop_pending;

    // The drive output follows the HIGH state one cycle late, so the pulse starts the cycle after start is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            counter         <= '0;
            width_l         <= '0;
            period_l        <= '0;
            num_l           <= '0;
            stop_pending    <= 1'b0;
            laser_pulse_out <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
            abort_flag      <= 1'b0;
            pulses_sent     <= '0;
        end else begin
            done            <= 1'b0;
            cfg_err         <= 1'b0;
            laser_pulse_out <= (state == HIGH);
`ifdef LASER_GEN_SAFETY_ABORT_EN
            if (safety_fail) begin
                state           <= FAULT;
                busy            <= 1'b0;
                laser_pulse_out <= 1'b0;
                abort_flag      <= 1'b1;
            end else
`endif
            if ((state == HIGH || state == LOW) && !laser_ready) begin
                state           <= IDLE;
                busy            <= 1'b0;
                laser_pulse_out <= 1'b0;
                abort_flag      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (pulse_width == '0 || pulse_period <= pulse_width || !laser_ready) begin
                                cfg_err <= 1'b1;
                            end else begin
                                width_l      <= pulse_width;
                                period_l     <= pulse_period;
                                num_l        <= pulse_num;
                                abort_flag   <= 1'b0;
                                pulses_sent  <= NUM_W'(1);
                                counter      <= CNT_W'(1);
                                stop_pending <= 1'b0;
                                busy         <= 1'b1;
                                state        <= HIGH;
                            end
                        end
                    end
                    HIGH: begin
                        stop_pending <= stop_pending | stop;
                        counter      <= counter + 1'b1;
                        if (counter == width_l) begin
                            state <= LOW;
                        end
                    end
                    LOW: begin
                        stop_pending <= stop_pending | stop;
                        // A stop request is honoured only here, so a started pulse is never shortened.
                        if (counter == period_l) begin
                            if ((num_l != '0 && pulses_sent == num_l) || stop_pending || stop) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                counter     <= CNT_W'(1);
                                pulses_sent <= pulses_sent + 1'b1;
                                state       <= HIGH;
                            end
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    FAULT: begin
                        if (!safety_fail && start) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_laser_pulse_gen.sv
// Self-checking bench for laser_pulse_gen: a table of config vectors, directed corner sequences and randomized trains
// checked against an arithmetic model of the pulse train (honours LASER_GEN_SAFETY_ABORT_EN when defined).
module tb_laser_pulse_gen;

    localparam int CNT_W = 32;
    localparam int NUM_W = 16;

    logic             clk;
    logic             rstn;
    logic             start;
    logic             stop;
    logic             laser_ready;
    logic             safety_fail;
    logic [CNT_W-1:0] pulse_width;
    logic [CNT_W-1:0] pulse_period;
    logic [NUM_W-1:0] pulse_num;
    logic             laser_pulse_out;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic             abort_flag;
    logic [NUM_W-1:0] pulses_sent;

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct {
        int width;
        int period;
        int num;
        bit ready;
        bit exp_cfg_err;
    } vec_t;

    vec_t vecs [7];

    laser_pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .stop            (stop),
        .laser_ready     (laser_ready),
        .safety_fail     (safety_fail),
        .pulse_width     (pulse_width),
        .pulse_period    (pulse_period),
        .pulse_num       (pulse_num),
        .laser_pulse_out (laser_pulse_out),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .abort_flag      (abort_flag),
        .pulses_sent     (pulses_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int st, input int sp, input int rdy, input int sf,
                                 input int w, input int p, input int n);
        start        = st[0];
        stop         = sp[0];
        laser_ready  = rdy[0];
        safety_fail  = sf[0];
        pulse_width  = CNT_W'(w);
        pulse_period = CNT_W'(p);
        pulse_num    = NUM_W'(n);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vectors++;
        if (actual != expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic checkAll(input int e_out, input int e_busy, input int e_done, input int e_cfg,
                            input int e_abort, input int e_pulses);
        checkOutput("laser_pulse_out", int'(laser_pulse_out), e_out);
        checkOutput("busy", int'(busy), e_busy);
        checkOutput("done", int'(done), e_done);
        checkOutput("cfg_err", int'(cfg_err), e_cfg);
        checkOutput("abort_flag", int'(abort_flag), e_abort);
        checkOutput("pulses_sent", int'(pulses_sent), e_pulses);
    endtask

    // Reference: start accepted at edge N; after edge N+t the drive is high when (t-1) mod period < width.
    // The train ends after num_eff*period state cycles; a ready drop at edge N+drop_d ends it with an abort.
    task automatic runTrain(input int w, input int p, input int num, input int drop_d, input int stop_t);
        int num_eff;
        int total;
        int end_t;
        num_eff = num;
        if (stop_t > 0) begin
            if (num == 0 || ((stop_t - 1) / p + 1) < num) num_eff = (stop_t - 1) / p + 1;
        end
        total = num_eff * p;
        end_t = (drop_d > 0) ? drop_d : total;
        applyStimulus(1, 0, 1, 0, w, p, num);
        for (int t = 0; t <= end_t + 1; t++) begin
            int e_out;
            int e_busy;
            int e_done;
            int e_abort;
            int e_pulses;
            int nt;
            int sf;
            tick();
            if (drop_d > 0 && t >= drop_d) begin
                e_out = 0; e_busy = 0; e_done = 0; e_abort = 1; e_pulses = (drop_d - 1) / p + 1;
            end else if (t >= total) begin
                e_out = 0; e_busy = 0; e_done = (t == total) ? 1 : 0; e_abort = 0; e_pulses = num_eff;
            end else begin
                e_busy = 1; e_done = 0; e_abort = 0; e_pulses = t / p + 1;
                e_out = (t >= 1 && ((t - 1) % p) < w) ? 1 : 0;
            end
            checkAll(e_out, e_busy, e_done, 0, e_abort, e_pulses);
            nt = t + 1;
`ifdef LASER_GEN_SAFETY_ABORT_EN
            sf = 0;
`else
            sf = int'($urandom_range(0, 1));
`endif
            applyStimulus((nt <= end_t) ? int'($urandom_range(0, 1)) : 0,
                          (stop_t > 0 && nt >= stop_t && nt <= end_t) ? 1 : 0,
                          (drop_d > 0 && nt == drop_d) ? 0 : 1,
                          sf,
                          int'($urandom_range(0, 9)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end
        applyStimulus(0, 0, 1, 0, w, p, num);
    endtask

    initial begin
        vecs = '{
            '{0, 20, 3, 1'b1, 1'b1},
            '{5, 5, 1, 1'b1, 1'b1},
            '{5, 4, 1, 1'b1, 1'b1},
            '{5, 20, 3, 1'b0, 1'b1},
            '{1, 2, 1, 1'b1, 1'b0},
            '{3, 4, 2, 1'b1, 1'b0},
            '{5, 20, 3, 1'b1, 1'b0}
        };

        rstn = 1'b1;
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        #3 rstn = 1'b0;
        tick();
        tick();
        checkAll(0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        tick();
        checkAll(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_cfg_err) begin
                applyStimulus(1, 0, int'(vecs[i].ready), 0, vecs[i].width, vecs[i].period, vecs[i].num);
                tick();
                checkOutput("cfg_err_reject", int'(cfg_err), int'(vecs[i].exp_cfg_err));
                checkOutput("busy_reject", int'(busy), 0);
                checkOutput("out_reject", int'(laser_pulse_out), 0);
                applyStimulus(0, 0, 1, 0, vecs[i].width, vecs[i].period, vecs[i].num);
                tick();
                checkOutput("cfg_err_one_cycle", int'(cfg_err), 0);
                checkOutput("out_after_reject", int'(laser_pulse_out), 0);
            end else begin
                runTrain(vecs[i].width, vecs[i].period, vecs[i].num, 0, 0);
            end
        end

        $display("[TB] stop in continuous mode, ready drop, re-start");
        runTrain(2, 4, 0, 0, 5);
        runTrain(10, 30, 1, 4, 0);
        runTrain(4, 7, 2, 0, 0);

`ifdef LASER_GEN_SAFETY_ABORT_EN
        $display("[TB] safety fault sequence");
        applyStimulus(1, 0, 1, 0, 3, 6, 2);
        tick();
        applyStimulus(0, 0, 1, 0, 3, 6, 2);
        tick();
        tick();
        checkOutput("out_before_fault", int'(laser_pulse_out), 1);
        applyStimulus(0, 0, 1, 1, 3, 6, 2);
        tick();
        checkAll(0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 1, 1, 3, 6, 2);
        tick();
        checkAll(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 1, 0, 3, 6, 2);
        tick();
        applyStimulus(1, 0, 1, 0, 3, 6, 2);
        tick();
        checkAll(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 1, 0, 3, 6, 2);
        tick();
        tick();
        checkAll(0, 0, 0, 0, 1, 1);
        runTrain(3, 6, 2, 0, 0);
`else
        $display("[TB] safety_fail held high without the abort feature");
        applyStimulus(0, 0, 1, 1, 3, 6, 2);
        tick();
        checkAll(0, 0, 0, 0, 0, 2);
        runTrain(3, 6, 2, 0, 0);
`endif

        $display("[TB] reset during HIGH");
        applyStimulus(1, 0, 1, 0, 4, 8, 2);
        tick();
        applyStimulus(0, 0, 1, 0, 4, 8, 2);
        tick();
        tick();
        checkOutput("out_before_reset", int'(laser_pulse_out), 1);
        #2 rstn = 1'b0;
        #1;
        checkAll(0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        tick();
        checkAll(0, 0, 0, 0, 0, 0);
        runTrain(4, 8, 2, 0, 0);

        $display("[TB] randomized trains");
        for (int i = 0; i < 40; i++) begin
            int w;
            int p;
            int num;
            int base;
            int stop_t;
            int drop_d;
            w      = int'($urandom_range(1, 5));
            p      = int'($urandom_range(w + 1, w + 6));
            num    = int'($urandom_range(0, 3));
            base   = (num == 0) ? 3 * p : num * p;
            stop_t = (num == 0 || $urandom_range(0, 2) == 0) ? int'($urandom_range(1, base)) : 0;
            drop_d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (stop_t > 0) ? stop_t : base)) : 0;
            runTrain(w, p, num, drop_d, stop_t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
